// File: rtl/comparator_exerciser.sv
// Self-test driver/checker for a 1-bit comparator: steps {x,y} through 00,01,10,11, holds each for DWELL cycles
// and samples z on the last cycle; a run takes 4*LOOPS*DWELL cycles from start to done, start is ignored while busy.
module comparator_exerciser #(
  parameter int unsigned DWELL     = 20,
  parameter int unsigned LOOPS     = 1,
  parameter logic [3:0]  EXP_TABLE = 4'b1001,
  parameter int unsigned ERRW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            x,
  output logic            y,
  input  logic            z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [1:0]      first_fail_idx
);

  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [LW-1:0] LOOP_LAST  = LW'(LOOPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [LW-1:0]   loop_q, loop_d;
  logic            x_d, y_d, busy_d, done_d, pass_d;
  logic [ERRW-1:0] err_d;
  logic [1:0]      ffi_d;
  logic            mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      dwell_q        <= '0;
      loop_q         <= '0;
      x              <= 1'b0;
      y              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      dwell_q        <= dwell_d;
      loop_q         <= loop_d;
      x              <= x_d;
      y              <= y_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_fail_idx <= ffi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    loop_d   = loop_q;
    busy_d   = busy;
    done_d   = done;
    pass_d   = pass;
    err_d    = err_count;
    ffi_d    = first_fail_idx;
    mismatch = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          dwell_d = '0;
          loop_d  = '0;
          err_d   = '0;
          ffi_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d  = '0;
          mismatch = (z != EXP_TABLE[{x, y}]);
          if (mismatch) begin
            if (err_count != '1) err_d = err_count + ERRW'(1);
            if (err_count == '0) ffi_d = {x, y};
          end
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else if (loop_q != LOOP_LAST) begin
            idx_d  = '0;
            loop_d = loop_q + LW'(1);
          end else begin
            // End of the final loop: pass reflects this last compare too.
            state_d = DONE;
            idx_d   = '0;
            loop_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Operands follow the vector index only while driving; parked at 00 otherwise.
    {x_d, y_d} = (state_d == DRIVE) ? idx_d : 2'b00;
  end

endmodule

// File: tb/tb_comparator_exerciser.sv
// Bench for comparator_exerciser: three instances (default, LOOPS=3/ERRW=2, DWELL=2) driven by
// programmable comparator responses and checked against a vector-level reference model.
module tb_comparator_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Instance 0: default parameters; z looked up from a programmable per-vector response.
  logic       rst0, start0, x0, y0, z0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [1:0] ffi0;
  logic [3:0] zvec0;
  logic [12:0] st0;
  assign z0  = zvec0[{x0, y0}];
  assign st0 = {busy0, done0, pass0, err0, ffi0};

  comparator_exerciser dut0 (
    .clk(clk), .rst(rst0), .start(start0), .x(x0), .y(y0), .z(z0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail_idx(ffi0)
  );

  // Instance 1: three loops, 2-bit saturating error counter.
  logic       rst1, start1, x1, y1, z1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [1:0] ffi1;
  logic [3:0] zvec1;
  logic [6:0] st1;
  assign z1  = zvec1[{x1, y1}];
  assign st1 = {busy1, done1, pass1, err1, ffi1};

  comparator_exerciser #(.LOOPS(3), .ERRW(2)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail_idx(ffi1)
  );

  // Instance 2: DWELL=2, z is wrong during the first cycle of every vector.
  logic       rst2, start2, x2, y2, z2, busy2, done2, pass2;
  logic [7:0] err2;
  logic [1:0] ffi2;
  logic [12:0] st2;
  logic [1:0] prev_xy2 = 2'b00;
  logic       prev_busy2 = 1'b0;
  logic       glitch2;
  always @(posedge clk) begin
    prev_xy2   <= {x2, y2};
    prev_busy2 <= busy2;
  end
  assign glitch2 = (busy2 & ~prev_busy2) | ({x2, y2} != prev_xy2);
  assign z2      = glitch2 ? (x2 ^ y2) : (x2 ~^ y2);
  assign st2     = {busy2, done2, pass2, err2, ffi2};

  comparator_exerciser #(.DWELL(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .x(x2), .y(y2), .z(z2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail_idx(ffi2)
  );

  // ---------------- reference model ----------------
  function automatic logic ref_z(input int v);
    return ((v >> 1) & 1) == (v & 1);
  endfunction

  function automatic logic [3:0] good_zvec();
    logic [3:0] r;
    for (int v = 0; v < 4; v++) r[v] = ref_z(v);
    return r;
  endfunction

  function automatic int exp_err(input logic [3:0] zv, input int loops, input int errw);
    int n = 0;
    for (int l = 0; l < loops; l++)
      for (int v = 0; v < 4; v++)
        if (zv[v] != ref_z(v)) n++;
    if (n > (1 << errw) - 1) n = (1 << errw) - 1;
    return n;
  endfunction

  function automatic int exp_ffi(input logic [3:0] zv);
    for (int v = 0; v < 4; v++)
      if (zv[v] != ref_z(v)) return v;
    return 0;
  endfunction

  function automatic logic [12:0] exp_st0(input logic [3:0] zv);
    int e = exp_err(zv, 1, 8);
    return {1'b0, 1'b1, (e == 0), 8'(e), 2'(exp_ffi(zv))};
  endfunction

  function automatic logic cur_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  // Returns at the falling edge just after the accepting rising edge.
  task automatic kick(input int which);
    @(negedge clk);
    case (which)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, inout int m);
    while (!cur_done(which) && m < limit) begin
      @(negedge clk);
      m++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    zvec0 = good_zvec(); zvec1 = good_zvec();
    repeat (3) @(negedge clk);
    checks++;
    if ({x0, y0, st0} !== 15'd0) $display("FAIL reset.dut0: got %h want 0", {x0, y0, st0});
    else passed++;
    checks++;
    if ({x1, y1, st1} !== 9'd0) $display("FAIL reset.dut1: got %h want 0", {x1, y1, st1});
    else passed++;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass_run();
    zvec0 = good_zvec();
    kick(0);
    for (int m = 0; m <= 80; m++) begin
      if (m < 80 && (m % 20 == 0 || m % 20 == 19)) begin
        checks++;
        if ({x0, y0} !== 2'(m / 20)) $display("FAIL pass_run.xy@%0d: got %b want %b", m, {x0, y0}, 2'(m / 20));
        else passed++;
      end
      if (m == 79) begin
        checks++;
        if (done0 !== 1'b0) $display("FAIL pass_run.early_done: got %b want 0", done0);
        else passed++;
      end
      if (m == 80) begin
        checks++;
        if ({x0, y0, st0} !== {2'b00, exp_st0(zvec0)})
          $display("FAIL pass_run.done@80: got %h want %h", {x0, y0, st0}, {2'b00, exp_st0(zvec0)});
        else passed++;
      end
      if (m < 80) @(negedge clk);
    end
  endtask

  task automatic test_tied();
    int m;
    for (int t = 0; t < 2; t++) begin
      zvec0 = (t == 0) ? 4'h0 : 4'hF;
      kick(0);
      m = 0;
      wait_done(0, 500, m);
      checks++;
      if (m !== 80) $display("FAIL tied%0d.latency: got %0d want 80", t, m);
      else passed++;
      checks++;
      if (st0 !== exp_st0(zvec0)) $display("FAIL tied%0d.result: got %h want %h", t, st0, exp_st0(zvec0));
      else passed++;
      repeat (10) @(negedge clk);
      checks++;
      if (st0 !== exp_st0(zvec0)) $display("FAIL tied%0d.hold: got %h want %h", t, st0, exp_st0(zvec0));
      else passed++;
    end
  endtask

  task automatic test_random();
    int m;
    for (int i = 0; i < 6; i++) begin
      zvec0 = 4'($urandom_range(0, 15));
      kick(0);
      m = 0;
      wait_done(0, 500, m);
      checks++;
      if (m !== 80) $display("FAIL random%0d.latency: got %0d want 80", i, m);
      else passed++;
      checks++;
      if (st0 !== exp_st0(zvec0))
        $display("FAIL random%0d.result: zvec=%b got %h want %h", i, zvec0, st0, exp_st0(zvec0));
      else passed++;
    end
  endtask

  task automatic test_start_held();
    int m;
    zvec0 = good_zvec();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    m = 0;
    repeat (49) begin
      @(negedge clk);
      m++;
    end
    start0 = 1'b0;
    wait_done(0, 500, m);
    checks++;
    if (m !== 80) $display("FAIL start_held.latency: got %0d want 80", m);
    else passed++;
    checks++;
    if (st0 !== exp_st0(zvec0)) $display("FAIL start_held.result: got %h want %h", st0, exp_st0(zvec0));
    else passed++;
  endtask

  task automatic test_back_to_back();
    int m;
    // From a passing DONE: done and pass must drop on the accepting edge.
    zvec0 = 4'h0;
    kick(0);
    checks++;
    if ({x0, y0, st0} !== {2'b00, 13'b1_0_0_00000000_00})
      $display("FAIL b2b.restart1: got %h want %h", {x0, y0, st0}, {2'b00, 13'b1_0_0_00000000_00});
    else passed++;
    m = 0;
    wait_done(0, 500, m);
    checks++;
    if (m !== 80 || st0 !== exp_st0(zvec0))
      $display("FAIL b2b.run1: got m=%0d st=%h want m=80 st=%h", m, st0, exp_st0(zvec0));
    else passed++;
    // From a failing DONE: error count and first-fail index clear on restart.
    zvec0 = good_zvec();
    kick(0);
    checks++;
    if (st0 !== 13'b1_0_0_00000000_00) $display("FAIL b2b.restart2: got %h want %h", st0, 13'b1_0_0_00000000_00);
    else passed++;
    m = 0;
    wait_done(0, 500, m);
    checks++;
    if (m !== 80 || st0 !== exp_st0(zvec0))
      $display("FAIL b2b.run2: got m=%0d st=%h want m=80 st=%h", m, st0, exp_st0(zvec0));
    else passed++;
  endtask

  task automatic test_mid_run_reset();
    int m;
    zvec0 = 4'h0;
    kick(0);
    repeat (35) @(negedge clk);
    checks++;
    if ({x0, y0, busy0, err0} !== {2'b01, 1'b1, 8'd1})
      $display("FAIL midrst.before: got %h want %h", {x0, y0, busy0, err0}, {2'b01, 1'b1, 8'd1});
    else passed++;
    rst0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({x0, y0, st0} !== 15'd0) $display("FAIL midrst.after: got %h want 0", {x0, y0, st0});
    else passed++;
    rst0 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({x0, y0, st0} !== 15'd0) $display("FAIL midrst.idle: got %h want 0", {x0, y0, st0});
    else passed++;
    zvec0 = good_zvec();
    kick(0);
    m = 0;
    wait_done(0, 500, m);
    checks++;
    if (m !== 80 || st0 !== exp_st0(zvec0))
      $display("FAIL midrst.fresh: got m=%0d st=%h want m=80 st=%h", m, st0, exp_st0(zvec0));
    else passed++;
  endtask

  task automatic test_saturate();
    int m;
    logic [6:0] want;
    for (int i = 0; i < 3; i++) begin
      zvec1 = (i == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      kick(1);
      m = 0;
      wait_done(1, 1000, m);
      checks++;
      if (m !== 240) $display("FAIL saturate%0d.latency: got %0d want 240", i, m);
      else passed++;
      want = {1'b0, 1'b1, (exp_err(zvec1, 3, 2) == 0), 2'(exp_err(zvec1, 3, 2)), 2'(exp_ffi(zvec1))};
      checks++;
      if (st1 !== want) $display("FAIL saturate%0d.result: zvec=%b got %h want %h", i, zvec1, st1, want);
      else passed++;
    end
  endtask

  task automatic test_dwell2_glitch();
    int m;
    kick(2);
    m = 0;
    wait_done(2, 200, m);
    checks++;
    if (m !== 8) $display("FAIL dwell2.latency: got %0d want 8", m);
    else passed++;
    checks++;
    if (st2 !== 13'b0_1_1_00000000_00) $display("FAIL dwell2.result: got %h want %h", st2, 13'b0_1_1_00000000_00);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_tied();
    test_random();
    test_start_held();
    test_back_to_back();
    test_mid_run_reset();
    test_saturate();
    test_dwell2_glitch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
